// File: rtl/mode_ctrl_mc.sv
// Multi-channel VCSEL mode controller: shadow/active config, STOP/WARMUP/RUN sequencing,
// manual or round-robin DAC sweep, all emission gated by temp_good_i.
module mode_ctrl_mc #(
    parameter int          NCH        = 4,
    parameter int          DAC_W      = 14,
    parameter int          CNT_W      = 16,
    parameter int          WARMUP_CYC = 20000,
    parameter logic [1:0]  CFG_BASE   = 2'b11,
    localparam int         CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i_n,
    input  logic              temp_good_i,
    input  logic [9:0]        const_addr,
    input  logic [64:0]       const_data,
    output logic [NCH-1:0]    vcsel_o_n,
    output logic              run_stb_o,
    output logic [DAC_W-1:0]  dac,
    output logic [CH_W-1:0]   ch_o,
    output logic [2:0]        sw_mode,
    output logic              cfg_err_o
);
    typedef enum logic [2:0] {ST_STOP = 3'b100, ST_WARM = 3'b010, ST_RUN = 3'b001} state_t;

    localparam int WW = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
    localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_CYC - 1);
    localparam int USED_W = (DAC_W > CNT_W) ? ((DAC_W > NCH) ? DAC_W : NCH)
                                            : ((CNT_W > NCH) ? CNT_W : NCH);
    localparam logic [7:0] A_DAC_MAN = 8'd10, A_OP_MODE = 8'd11, A_MODE_CTRL = 8'd12,
                           A_MAX = 8'd13, A_MIN = 8'd14, A_SWITCH = 8'd15,
                           A_STEP = 8'd16, A_STEP_DIV = 8'd17;

    logic [DAC_W-1:0] sh_dac_man_q, sh_dac_man_d, act_dac_man_q, act_dac_man_d;
    logic [2:0]       sh_op_q, sh_op_d, act_op_q, act_op_d;
    logic [NCH-1:0]   sh_mask_q, sh_mask_d, act_mask_q, act_mask_d;
    logic [DAC_W-1:0] sh_max_q, sh_max_d, act_max_q, act_max_d;
    logic [DAC_W-1:0] sh_min_q, sh_min_d, act_min_q, act_min_d;
    logic [DAC_W-1:0] sh_step_q, sh_step_d, act_step_q, act_step_d;
    logic [CNT_W-1:0] sh_div_q, sh_div_d, act_div_q, act_div_d;
    logic             lock_q, lock_d, err_q, err_d;
    state_t           state_q, state_d;
    logic [WW-1:0]    warm_q, warm_d;
    logic [DAC_W-1:0] swp_dac_q, swp_dac_d;
    logic [CH_W-1:0]  swp_ch_q, swp_ch_d, first_ch, next_ch;
    logic [CNT_W-1:0] div_q, div_d;
    logic             stb_q, stb_d;
    logic             wr_en, commit, enter_run;
    logic             is_man, is_swp, swp_ok;
    logic [DAC_W-1:0] step_eff;
    logic [DAC_W:0]   swp_sum;
    logic [NCH-1:0]   vcsel_raw;
    logic             unused_data;

    assign unused_data = ^const_data[64:USED_W];
    assign is_man   = (act_op_q == 3'b001);
    assign is_swp   = (act_op_q == 3'b011);
    assign swp_ok   = (act_min_q <= act_max_q) && (|act_mask_q);
    assign step_eff = (act_step_q == '0) ? DAC_W'(1) : act_step_q;
    assign swp_sum  = {1'b0, swp_dac_q} + {1'b0, step_eff};

    always_comb begin
        sh_dac_man_d = sh_dac_man_q;  act_dac_man_d = act_dac_man_q;
        sh_op_d      = sh_op_q;       act_op_d      = act_op_q;
        sh_mask_d    = sh_mask_q;     act_mask_d    = act_mask_q;
        sh_max_d     = sh_max_q;      act_max_d     = act_max_q;
        sh_min_d     = sh_min_q;      act_min_d     = act_min_q;
        sh_step_d    = sh_step_q;     act_step_d    = act_step_q;
        sh_div_d     = sh_div_q;      act_div_d     = act_div_q;
        lock_d       = lock_q;
        err_d        = err_q;
        wr_en  = (const_addr[9:8] == CFG_BASE);
        commit = wr_en && (const_addr[7:0] == A_SWITCH) && !const_data[0] && lock_q;
        if (wr_en) begin
            case (const_addr[7:0])
                A_DAC_MAN:   sh_dac_man_d = const_data[DAC_W-1:0];
                A_OP_MODE:   sh_op_d      = const_data[2:0];
                A_MODE_CTRL: sh_mask_d    = const_data[NCH-1:0];
                A_MAX:       sh_max_d     = const_data[DAC_W-1:0];
                A_MIN:       sh_min_d     = const_data[DAC_W-1:0];
                A_SWITCH:    lock_d       = const_data[0];
                A_STEP:      sh_step_d    = const_data[DAC_W-1:0];
                A_STEP_DIV:  sh_div_d     = const_data[CNT_W-1:0];
                default:     ;
            endcase
        end
        // Error is judged once at commit; the active set cannot change until the next one.
        if (commit) begin
            act_dac_man_d = sh_dac_man_q;
            act_op_d      = sh_op_q;
            act_mask_d    = sh_mask_q;
            act_max_d     = sh_max_q;
            act_min_d     = sh_min_q;
            act_step_d    = sh_step_q;
            act_div_d     = sh_div_q;
            err_d = (sh_op_q == 3'b011) && ((sh_min_q > sh_max_q) || (sh_mask_q == '0));
        end
    end

    // Descending scans: the last hit wins, giving the lowest qualifying index.
    always_comb begin
        first_ch = '0;
        for (int i = NCH - 1; i >= 0; i--)
            if (act_mask_q[i]) first_ch = CH_W'(i);
        next_ch = first_ch;
        for (int i = NCH - 1; i >= 0; i--)
            if (act_mask_q[i] && (i > int'(swp_ch_q))) next_ch = CH_W'(i);
    end

    always_comb begin
        state_d   = state_q;
        warm_d    = '0;
        swp_dac_d = swp_dac_q;
        swp_ch_d  = swp_ch_q;
        div_d     = div_q;
        stb_d     = 1'b0;
        case (state_q)
            ST_STOP: if (!lock_q) state_d = ST_WARM;
            ST_WARM: begin
                if (warm_q == WARM_LAST) state_d = ST_RUN;
                else                     warm_d  = warm_q + 1'b1;
            end
            ST_RUN:  ;
            default: state_d = ST_STOP;
        endcase
        if (!temp_good_i || commit) begin
            state_d = ST_STOP;
            warm_d  = '0;
        end
        enter_run = (state_q == ST_WARM) && (state_d == ST_RUN);
        if (enter_run) begin
            swp_dac_d = act_min_q;
            swp_ch_d  = first_ch;
            div_d     = '0;
            stb_d     = 1'b1;
        end else if ((state_q == ST_RUN) && is_swp && swp_ok && !lock_q) begin
            if (div_q == act_div_q) begin
                div_d = '0;
                if (swp_sum > {1'b0, act_max_q}) begin
                    swp_dac_d = act_min_q;
                    swp_ch_d  = next_ch;
                    stb_d     = 1'b1;
                end else begin
                    swp_dac_d = swp_sum[DAC_W-1:0];
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_comb begin
        vcsel_raw = '1;
        dac       = '0;
        ch_o      = '0;
        run_stb_o = 1'b0;
        if ((state_q == ST_RUN) && !lock_q) begin
            if (is_man) begin
                dac = act_dac_man_q;
                if (|act_mask_q) begin
                    ch_o = first_ch;
                    vcsel_raw[first_ch] = 1'b0;
                end
            end else if (is_swp) begin
                if (swp_ok) begin
                    dac       = swp_dac_q;
                    ch_o      = swp_ch_q;
                    run_stb_o = stb_q;
                    vcsel_raw[swp_ch_q] = 1'b0;
                end else begin
                    dac = act_min_q;
                end
            end
        end
    end

    assign vcsel_o_n = temp_good_i ? vcsel_raw : '1;
    assign sw_mode   = state_q;
    assign cfg_err_o = err_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i_n) begin
            sh_dac_man_q <= '0;  act_dac_man_q <= '0;
            sh_op_q      <= '0;  act_op_q      <= '0;
            sh_mask_q    <= '1;  act_mask_q    <= '1;
            sh_max_q     <= '1;  act_max_q     <= '1;
            sh_min_q     <= '0;  act_min_q     <= '0;
            sh_step_q    <= '0;  act_step_q    <= '0;
            sh_div_q     <= '0;  act_div_q     <= '0;
            lock_q       <= 1'b0;
            err_q        <= 1'b0;
            state_q      <= ST_STOP;
            warm_q       <= '0;
            swp_dac_q    <= '0;
            swp_ch_q     <= '0;
            div_q        <= '0;
            stb_q        <= 1'b0;
        end else begin
            sh_dac_man_q <= sh_dac_man_d;  act_dac_man_q <= act_dac_man_d;
            sh_op_q      <= sh_op_d;       act_op_q      <= act_op_d;
            sh_mask_q    <= sh_mask_d;     act_mask_q    <= act_mask_d;
            sh_max_q     <= sh_max_d;      act_max_q     <= act_max_d;
            sh_min_q     <= sh_min_d;      act_min_q     <= act_min_d;
            sh_step_q    <= sh_step_d;     act_step_q    <= act_step_d;
            sh_div_q     <= sh_div_d;      act_div_q     <= act_div_d;
            lock_q       <= lock_d;
            err_q        <= err_d;
            state_q      <= state_d;
            warm_q       <= warm_d;
            swp_dac_q    <= swp_dac_d;
            swp_ch_q     <= swp_ch_d;
            div_q        <= div_d;
            stb_q        <= stb_d;
        end
    end
endmodule

// File: tb/tb_mode_ctrl_mc.sv
// Self-checking bench for mode_ctrl_mc: sweep expectations come from a small behavioural
// model pushed into a scoreboard queue and popped cycle by cycle.
module tb_mode_ctrl_mc;
    localparam int NCH = 4, DAC_W = 14, CNT_W = 16, W = 64;

    logic             clk = 1'b0, rst_i_n = 1'b0, temp_good_i = 1'b1;
    logic [9:0]       const_addr = '0;
    logic [64:0]      const_data = '0;
    logic [NCH-1:0]   vcsel_o_n;
    logic             run_stb_o, cfg_err_o;
    logic [DAC_W-1:0] dac;
    logic [1:0]       ch_o;
    logic [2:0]       sw_mode;

    int n_checks = 0, n_errors = 0;

    typedef struct {
        logic [DAC_W-1:0] dac;
        logic [1:0]       ch;
        logic             stb;
        logic [NCH-1:0]   vcsel;
    } exp_t;
    exp_t sb[$];

    mode_ctrl_mc #(.NCH(NCH), .DAC_W(DAC_W), .CNT_W(CNT_W), .WARMUP_CYC(W), .CFG_BASE(2'b11)) dut (
        .clk_i(clk), .rst_i_n(rst_i_n), .temp_good_i(temp_good_i),
        .const_addr(const_addr), .const_data(const_data),
        .vcsel_o_n(vcsel_o_n), .run_stb_o(run_stb_o), .dac(dac), .ch_o(ch_o),
        .sw_mode(sw_mode), .cfg_err_o(cfg_err_o));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [64:0] d);
        const_addr = {2'b11, a};
        const_data = d;
        tick();
        const_addr = '0;
        const_data = '0;
    endtask

    task automatic wait_run(input string tag);
        int cyc = 0;
        while (sw_mode !== 3'b001 && cyc < W + 20) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (sw_mode !== 3'b001) begin
            n_errors++;
            $display("FAIL %s_reach_run: sw_mode=%b after %0d cycles, required 001", tag, sw_mode, cyc);
        end
    endtask

    function automatic int m_low(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic int m_next(input int c, input logic [3:0] m);
        for (int k = 1; k <= 4; k++) if (m[(c + k) % 4]) return (c + k) % 4;
        return c;
    endfunction

    task automatic gen(input int mn, input int mx, input int st, input int dv,
                       input logic [3:0] mask, input int n);
        int   dac_m = mn, d = 0, ch = m_low(mask);
        int   stp = (st == 0) ? 1 : st;
        logic stb = 1'b1;
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.dac = DAC_W'(dac_m);
            e.ch = 2'(ch);
            e.stb = stb;
            e.vcsel = ~(4'b0001 << ch);
            sb.push_back(e);
            stb = 1'b0;
            if (d == dv) begin
                d = 0;
                if (dac_m + stp > mx) begin
                    dac_m = mn;
                    ch = m_next(ch, mask);
                    stb = 1'b1;
                end else begin
                    dac_m = dac_m + stp;
                end
            end else begin
                d++;
            end
        end
    endtask

    task automatic test_reset();
        rst_i_n = 1'b0;
        temp_good_i = 1'b1;
        repeat (10) tick();
        n_checks += 6;
        if (vcsel_o_n !== 4'b1111) begin n_errors++; $display("FAIL rst_vcsel: got %b, required 1111", vcsel_o_n); end
        if (dac !== '0) begin n_errors++; $display("FAIL rst_dac: got %0d, required 0", dac); end
        if (run_stb_o !== 1'b0) begin n_errors++; $display("FAIL rst_stb: got %b, required 0", run_stb_o); end
        if (sw_mode !== 3'b100) begin n_errors++; $display("FAIL rst_sw_mode: got %b, required 100", sw_mode); end
        if (ch_o !== 2'd0) begin n_errors++; $display("FAIL rst_ch: got %0d, required 0", ch_o); end
        if (cfg_err_o !== 1'b0) begin n_errors++; $display("FAIL rst_err: got %b, required 0", cfg_err_o); end
        rst_i_n = 1'b1;
        tick();
        n_checks++;
        if (sw_mode !== 3'b010) begin n_errors++; $display("FAIL rel_warmup: got %b, required 010", sw_mode); end
        begin
            int cyc = 0;
            while (sw_mode !== 3'b001 && cyc < W + 20) begin
                tick();
                cyc++;
            end
            n_checks++;
            if (cyc !== W || sw_mode !== 3'b001) begin
                n_errors++;
                $display("FAIL warmup_len: got %0d cycles (sw_mode=%b), required %0d cycles to 001", cyc, sw_mode, W);
            end
        end
    endtask

    task automatic test_manual();
        wr(8'd15, 65'd1);
        wr(8'd11, 65'd1);
        wr(8'd10, 65'h123);
        wr(8'd12, 65'b0100);
        wr(8'd15, 65'd0);
        n_checks++;
        if (sw_mode !== 3'b100) begin n_errors++; $display("FAIL commit_stop: got %b, required 100", sw_mode); end
        tick();
        n_checks++;
        if (sw_mode !== 3'b010) begin n_errors++; $display("FAIL commit_warmup: got %b, required 010", sw_mode); end
        wait_run("manual");
        n_checks += 4;
        if (dac !== 14'h123) begin n_errors++; $display("FAIL man_dac: got %h, required 123", dac); end
        if (ch_o !== 2'd2) begin n_errors++; $display("FAIL man_ch: got %0d, required 2", ch_o); end
        if (vcsel_o_n !== 4'b1011) begin n_errors++; $display("FAIL man_vcsel: got %b, required 1011", vcsel_o_n); end
        if (run_stb_o !== 1'b0) begin n_errors++; $display("FAIL man_stb: got %b, required 0", run_stb_o); end
    endtask

    task automatic test_lock();
        wr(8'd15, 65'd1);
        n_checks += 2;
        if (vcsel_o_n !== 4'b1111) begin n_errors++; $display("FAIL lock_vcsel: got %b, required 1111", vcsel_o_n); end
        if (dac !== '0) begin n_errors++; $display("FAIL lock_dac: got %0d, required 0", dac); end
    endtask

    task automatic test_sweep(input string tag, input int mn, input int mx, input int st,
                              input int dv, input logic [3:0] mask, input int n);
        exp_t e;
        wr(8'd15, 65'd1);
        wr(8'd11, 65'd3);
        wr(8'd14, 65'(mn));
        wr(8'd13, 65'(mx));
        wr(8'd16, 65'(st));
        wr(8'd17, 65'(dv));
        wr(8'd12, 65'(mask));
        wr(8'd15, 65'd0);
        wait_run(tag);
        gen(mn, mx, st, dv, mask, n);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks += 4;
            if (dac !== e.dac) begin n_errors++; $display("FAIL %s_dac: got %0d, required %0d", tag, dac, e.dac); end
            if (ch_o !== e.ch) begin n_errors++; $display("FAIL %s_ch: got %0d, required %0d", tag, ch_o, e.ch); end
            if (run_stb_o !== e.stb) begin n_errors++; $display("FAIL %s_stb: got %b, required %b", tag, run_stb_o, e.stb); end
            if (vcsel_o_n !== e.vcsel) begin n_errors++; $display("FAIL %s_vcsel: got %b, required %b", tag, vcsel_o_n, e.vcsel); end
            tick();
        end
    endtask

    task automatic test_temp_drop();
        exp_t e;
        temp_good_i = 1'b0;
        #1;
        n_checks += 2;
        if (vcsel_o_n !== 4'b1111) begin n_errors++; $display("FAIL tdrop_vcsel: got %b, required 1111", vcsel_o_n); end
        if (sw_mode !== 3'b001) begin n_errors++; $display("FAIL tdrop_same_cycle_mode: got %b, required 001", sw_mode); end
        tick();
        n_checks++;
        if (sw_mode !== 3'b100) begin n_errors++; $display("FAIL tdrop_stop: got %b, required 100", sw_mode); end
        repeat (9) tick();
        temp_good_i = 1'b1;
        tick();
        n_checks++;
        if (sw_mode !== 3'b010) begin n_errors++; $display("FAIL traise_warmup: got %b, required 010", sw_mode); end
        wait_run("tresume");
        gen(10, 20, 4, 0, 4'b1010, 6);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks += 3;
            if (dac !== e.dac) begin n_errors++; $display("FAIL tresume_dac: got %0d, required %0d", dac, e.dac); end
            if (ch_o !== e.ch) begin n_errors++; $display("FAIL tresume_ch: got %0d, required %0d", ch_o, e.ch); end
            if (run_stb_o !== e.stb) begin n_errors++; $display("FAIL tresume_stb: got %b, required %b", run_stb_o, e.stb); end
            tick();
        end
    endtask

    task automatic test_cfg_err();
        exp_t e;
        wr(8'd15, 65'd1);
        wr(8'd14, 65'd30);
        wr(8'd15, 65'd0);
        n_checks++;
        if (cfg_err_o !== 1'b1) begin n_errors++; $display("FAIL err_set: got %b, required 1", cfg_err_o); end
        wait_run("err");
        repeat (3) begin
            n_checks += 3;
            if (vcsel_o_n !== 4'b1111) begin n_errors++; $display("FAIL err_vcsel: got %b, required 1111", vcsel_o_n); end
            if (dac !== 14'd30) begin n_errors++; $display("FAIL err_dac: got %0d, required 30", dac); end
            if (run_stb_o !== 1'b0) begin n_errors++; $display("FAIL err_stb: got %b, required 0", run_stb_o); end
            tick();
        end
        wr(8'd15, 65'd1);
        wr(8'd14, 65'd5);
        n_checks++;
        if (cfg_err_o !== 1'b1) begin n_errors++; $display("FAIL err_sticky: got %b, required 1", cfg_err_o); end
        wr(8'd15, 65'd0);
        n_checks++;
        if (cfg_err_o !== 1'b0) begin n_errors++; $display("FAIL err_clear: got %b, required 0", cfg_err_o); end
        wait_run("recommit");
        gen(5, 20, 4, 0, 4'b1010, 10);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks += 3;
            if (dac !== e.dac) begin n_errors++; $display("FAIL recommit_dac: got %0d, required %0d", dac, e.dac); end
            if (ch_o !== e.ch) begin n_errors++; $display("FAIL recommit_ch: got %0d, required %0d", ch_o, e.ch); end
            if (vcsel_o_n !== e.vcsel) begin n_errors++; $display("FAIL recommit_vcsel: got %b, required %b", vcsel_o_n, e.vcsel); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        rst_i_n = 1'b0;
        tick();
        n_checks += 6;
        if (vcsel_o_n !== 4'b1111) begin n_errors++; $display("FAIL mid_rst_vcsel: got %b, required 1111", vcsel_o_n); end
        if (dac !== '0) begin n_errors++; $display("FAIL mid_rst_dac: got %0d, required 0", dac); end
        if (run_stb_o !== 1'b0) begin n_errors++; $display("FAIL mid_rst_stb: got %b, required 0", run_stb_o); end
        if (ch_o !== 2'd0) begin n_errors++; $display("FAIL mid_rst_ch: got %0d, required 0", ch_o); end
        if (sw_mode !== 3'b100) begin n_errors++; $display("FAIL mid_rst_mode: got %b, required 100", sw_mode); end
        if (cfg_err_o !== 1'b0) begin n_errors++; $display("FAIL mid_rst_err: got %b, required 0", cfg_err_o); end
        rst_i_n = 1'b1;
        const_addr = {2'b01, 8'd11}; const_data = 65'd1;    tick();
        const_addr = {2'b10, 8'd10}; const_data = 65'h55;   tick();
        const_addr = {2'b00, 8'd12}; const_data = 65'b0010; tick();
        const_addr = '0; const_data = '0;
        wr(8'd15, 65'd1);
        wr(8'd15, 65'd0);
        wait_run("badbase");
        n_checks += 4;
        if (dac !== '0) begin n_errors++; $display("FAIL badbase_dac: got %0d, required 0", dac); end
        if (vcsel_o_n !== 4'b1111) begin n_errors++; $display("FAIL badbase_vcsel: got %b, required 1111", vcsel_o_n); end
        if (ch_o !== 2'd0) begin n_errors++; $display("FAIL badbase_ch: got %0d, required 0", ch_o); end
        if (run_stb_o !== 1'b0) begin n_errors++; $display("FAIL badbase_stb: got %b, required 0", run_stb_o); end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_lock();
        test_sweep("sweep", 10, 20, 4, 0, 4'b1010, 9);
        test_temp_drop();
        test_cfg_err();
        test_sweep("sweep_div", 3, 5, 0, 2, 4'b1000, 12);
        test_sweep("sweep_top", 16380, 16383, 3, 1, 4'b1101, 12);
        repeat (3) tick();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
